// File: rtl/div_event_scheduler.sv
// div_event_scheduler
//   Shared divide-by-N event engine. Up to NUM_CH requesters ask for
//   "signal me after N events". One request is granted at a time. The
//   granted job counts EVT strobes up to its divisor. Completion is then
//   held on a 4-phase REQ/GNT/DONE handshake.
//
// Configuration macro:
//   DIVSCHED_RR_EN  defined   : round-robin arbitration. The search starts
//                               at an internal pointer, and the pointer moves
//                               past each winner (grant or rejection).
//                   undefined : fixed priority, lowest index wins.
//
// Ports:
//   CLK    in   1           clock; all state changes on the falling edge
//   CLEAR  in   1           asynchronous active-high reset
//   REQ    in   NUM_CH      per-channel request level
//   DIV    in   NUM_CH*CW   per-channel divisor, channel i at DIV[i*CW +: CW]
//   EVT    in   1           event strobe, one event per high cycle
//   GNT    out  NUM_CH      one-hot grant, zero when idle
//   DONE   out  NUM_CH      one-hot completion level of the granted channel
//   ERR    out  NUM_CH      one-cycle pulse when a zero divisor is rejected
//   BUSY   out  1           a job is counting or waiting for release
//   Count  out  CW          event count of the active job
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no job; arbitrate among REQ, reject zero divisors
// S_COUNT | job granted; count EVT until divisor reached, abort on REQ drop
// S_REL   | DONE held until the winner drops REQ
module div_event_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CW     = 8
) (
  input  logic                 CLK,
  input  logic                 CLEAR,
  input  logic [NUM_CH-1:0]    REQ,
  input  logic [NUM_CH*CW-1:0] DIV,
  input  logic                 EVT,
  output logic [NUM_CH-1:0]    GNT,
  output logic [NUM_CH-1:0]    DONE,
  output logic [NUM_CH-1:0]    ERR,
  output logic                 BUSY,
  output logic [CW-1:0]        Count
);

  localparam int IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_REL   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       win_q, win_d;
  logic [CW-1:0]       div_q, div_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]   err_q, err_d;
`ifdef DIVSCHED_RR_EN
  logic [IW-1:0]       ptr_q, ptr_d;
`endif

  logic                any_req;
  logic                found;
  logic [IW1-1:0]      cand;
  logic [IW-1:0]       win;
  logic [CW-1:0]       win_div;

  // Arbiter: the first requesting channel found, scanning upward from the
  // start index with wrap-around.
  always_comb begin
    any_req = |REQ;
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef DIVSCHED_RR_EN
      cand = {1'b0, ptr_q} + IW1'(k);
      if (cand >= IW1'(NUM_CH)) cand = cand - IW1'(NUM_CH);
`else
      cand = IW1'(k);
`endif
      if (!found && REQ[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
    win_div = DIV[win*CW +: CW];
  end

  // State register
  always_ff @(negedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
`ifdef DIVSCHED_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef DIVSCHED_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    err_d   = '0;
`ifdef DIVSCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
`ifdef DIVSCHED_RR_EN
          ptr_d = (win == IW'(NUM_CH - 1)) ? '0 : win + 1'b1;
`endif
          if (win_div == '0) begin
            err_d[win] = 1'b1;
          end else begin
            state_d = S_COUNT;
            win_d   = win;
            div_d   = win_div;
            cnt_d   = '0;
          end
        end
      end
      S_COUNT: begin
        // A dropped request aborts even when EVT is high on the same edge.
        if (!REQ[win_q]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (EVT) begin
          if (cnt_q == div_q - 1'b1) begin
            cnt_d   = '0;
            state_d = S_REL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REL: begin
        if (!REQ[win_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    GNT  = '0;
    DONE = '0;
    if (state_q != S_IDLE) GNT[win_q]  = 1'b1;
    if (state_q == S_REL)  DONE[win_q] = 1'b1;
    BUSY  = (state_q != S_IDLE);
    ERR   = err_q;
    Count = cnt_q;
  end

endmodule

// File: tb/tb_div_event_scheduler.sv
module tb_div_event_scheduler;

  localparam int NUM_CH = 4;
  localparam int CW     = 8;

  logic                 CLK;
  logic                 CLEAR;
  logic [NUM_CH-1:0]    REQ;
  logic [NUM_CH*CW-1:0] DIV;
  logic                 EVT;
  logic [NUM_CH-1:0]    GNT, DONE, ERR;
  logic                 BUSY;
  logic [CW-1:0]        Count;

  int n_chk = 0;
  int n_err = 0;

  div_event_scheduler #(.NUM_CH(NUM_CH), .CW(CW)) dut (
    .CLK(CLK), .CLEAR(CLEAR), .REQ(REQ), .DIV(DIV), .EVT(EVT),
    .GNT(GNT), .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .Count(Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the active job is a channel number plus the number of
  // events still owed; Count is derived as divisor minus events remaining.
  int          act    = -1;
  int          m_div  = 0;
  int          m_left = 0;
  bit          m_rel  = 0;
  int          m_ptr  = 0;
  logic [NUM_CH-1:0] m_err = '0;
  int          mw, md;

  function automatic int pick(logic [NUM_CH-1:0] r, int p);
    for (int k = 0; k < NUM_CH; k++) begin
      int i;
      i = (p + k) % NUM_CH;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      act = -1; m_div = 0; m_left = 0; m_rel = 0; m_ptr = 0; m_err = '0;
    end else begin
      m_err = '0;
      if (act < 0) begin
        if (REQ != '0) begin
          mw = pick(REQ, m_ptr);
          md = int'(DIV[mw*CW +: CW]);
`ifdef DIVSCHED_RR_EN
          m_ptr = (mw + 1) % NUM_CH;
`endif
          if (md == 0) m_err[mw] = 1'b1;
          else begin
            act = mw; m_div = md; m_left = md; m_rel = 0;
          end
        end
      end else if (!m_rel) begin
        if (!REQ[act]) act = -1;
        else if (EVT) begin
          m_left = m_left - 1;
          if (m_left == 0) m_rel = 1;
        end
      end else begin
        if (!REQ[act]) act = -1;
      end
    end
  end

  logic [NUM_CH-1:0] e_gnt, e_done;
  logic              e_busy;
  logic [CW-1:0]     e_cnt;

  always @(posedge CLK) begin
    if (!CLEAR) begin
      e_gnt  = (act >= 0) ? NUM_CH'(1) << act : '0;
      e_done = (act >= 0 && m_rel) ? NUM_CH'(1) << act : '0;
      e_busy = (act >= 0);
      e_cnt  = (act >= 0 && !m_rel) ? CW'(m_div - m_left) : '0;
      n_chk++;
      if (GNT !== e_gnt || DONE !== e_done || ERR !== m_err ||
          BUSY !== e_busy || Count !== e_cnt) begin
        n_err++;
        $display("FAIL model t=%0t got gnt=%b done=%b err=%b busy=%b cnt=%0d exp gnt=%b done=%b err=%b busy=%b cnt=%0d",
                 $time, GNT, DONE, ERR, BUSY, Count, e_gnt, e_done, m_err, e_busy, e_cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, a, e);
    end
  endtask

  // One falling edge happens inside each call; returns at posedge+1.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_div(input int c, input int v);
    DIV[c*CW +: CW] = CW'(v);
  endtask

  logic [NUM_CH-1:0] ord [5];

  initial begin
    CLEAR = 1'b1; REQ = '0; DIV = '0; EVT = 1'b0;
    cyc(); cyc();
    CLEAR = 1'b0;
    cyc();
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_cnt", 32'(Count), 0);

    // Divide by 5 with EVT every cycle
    set_div(0, 5); REQ = 4'b0001; EVT = 1'b1;
    cyc();
    chk("t1_gnt", 32'(GNT), 32'h1);
    chk("t1_busy", 32'(BUSY), 1);
    chk("t1_cnt0", 32'(Count), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("t1_cnt", 32'(Count), 32'(k));
      chk("t1_nodone", 32'(DONE), 0);
    end
    cyc();
    chk("t1_done", 32'(DONE), 32'h1);
    chk("t1_cnt_done", 32'(Count), 0);
    REQ = '0;
    cyc();
    chk("t1_rel_gnt", 32'(GNT), 0);
    chk("t1_rel_done", 32'(DONE), 0);

    // Divide by 1 with sparse EVT
    set_div(1, 1); REQ = 4'b0010; EVT = 1'b0;
    cyc();
    chk("t2_gnt", 32'(GNT), 32'h2);
    for (int k = 0; k < 3; k++) begin
      EVT = (k == 2);
      cyc();
      chk("t2_cnt", 32'(Count), 0);
      chk("t2_done", 32'(DONE), (k == 2) ? 32'h2 : 32'h0);
    end
    EVT = 1'b0; REQ = '0;
    cyc();
    chk("t2_rel", 32'(GNT), 0);

    // Zero divisor rejected
    set_div(2, 0); REQ = 4'b0100;
    cyc();
    chk("t3_err", 32'(ERR), 32'h4);
    chk("t3_gnt", 32'(GNT), 0);
    chk("t3_busy", 32'(BUSY), 0);
    REQ = '0;
    cyc();
    chk("t3_err_clr", 32'(ERR), 0);

    // Abort at Count=4 with EVT high
    set_div(3, 10); REQ = 4'b1000; EVT = 1'b1;
    cyc();
    repeat (4) cyc();
    chk("t4_cnt4", 32'(Count), 4);
    REQ = '0;
    cyc();
    chk("t4_gnt", 32'(GNT), 0);
    chk("t4_cnt", 32'(Count), 0);
    chk("t4_done", 32'(DONE), 0);
    chk("t4_busy", 32'(BUSY), 0);

    // All channels requesting, re-requested after each release
`ifdef DIVSCHED_RR_EN
    ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100; ord[3] = 4'b1000; ord[4] = 4'b0001;
`else
    for (int j = 0; j < 5; j++) ord[j] = 4'b0001;
`endif
    for (int c = 0; c < NUM_CH; c++) set_div(c, 2);
    REQ = 4'b1111; EVT = 1'b1;
    cyc();
    for (int j = 0; j < 5; j++) begin
      chk("t5_order", 32'(GNT), 32'(ord[j]));
      cyc(); cyc();
      chk("t5_done", 32'(DONE), 32'(ord[j]));
      REQ = 4'b1111 & ~ord[j];
      cyc();
      chk("t5_gap", 32'(GNT), 0);
      REQ = 4'b1111;
      cyc();
    end
    REQ = '0;
    repeat (4) cyc();

    // Asynchronous clear mid-count
    set_div(0, 10); REQ = 4'b0001; EVT = 1'b1;
    cyc(); cyc(); cyc();
    chk("t6_cnt", 32'(Count), 2);
    #1 CLEAR = 1'b1;
    #1;
    chk("t6_gnt", 32'(GNT), 0);
    chk("t6_busy", 32'(BUSY), 0);
    chk("t6_cnt0", 32'(Count), 0);
    chk("t6_done", 32'(DONE), 0);
    CLEAR = 1'b0;
    cyc();
    chk("t6_regnt", 32'(GNT), 32'h1);
    REQ = '0;
    cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0) REQ[c] = ~REQ[c];
        set_div(c, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)));
      end
      EVT   = ($urandom_range(0, 2) != 0);
      CLEAR = ($urandom_range(0, 499) == 0);
      cyc();
    end
    CLEAR = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_event_scheduler.md
# div_event_scheduler

Shared event-divider engine with a request/grant front end. Up to `NUM_CH` requesters each ask for "signal me after N input events". The block arbitrates between them, then runs one divide-by-N count at a time on the shared `EVT` strobe. It reports completion on a per-channel 4-phase handshake. It sits between the clients that need divided event ticks and the single event source, replacing one private divide-by-N counter per client.

## Interface
Parameters:
- `NUM_CH`, default 4: number of requesters (2..8).
- `CW`, default 8: count/divisor width. Maximum divisor is 2^CW−1.

Ports:
- `CLK`  in  1: clock. All state updates on the falling edge.
- `CLEAR`  in  1: reset. Asynchronous, active-high.
- `REQ`  in  NUM_CH: per-channel request level, held until released per the handshake.
- `DIV`  in  NUM_CH*CW: per-channel divisor. Channel i is `DIV[i*CW +: CW]`. Sampled only at grant.
- `EVT`  in  1: event strobe, one event per cycle it is high.
- `GNT`  out  NUM_CH: one-hot grant; all zero when idle.
- `DONE`  out  NUM_CH: one-hot completion level for the granted channel.
- `ERR`  out  NUM_CH: one-cycle pulse when a zero divisor is rejected.
- `BUSY`  out  1: high in COUNT or REL.
- `Count`  out  CW: current event count of the active job.

## Operation
- The state machine has three states: IDLE, COUNT and REL.
- **IDLE**:
  - If no bit of `REQ` is high, remain in IDLE.
  - Otherwise the arbiter picks a winner `w`.
  - If `DIV[w]` is 0: pulse `ERR[w]` for one cycle, assert no grant, advance the arbitration pointer, and stay in IDLE.
  - Otherwise: latch `DIV[w]` into `div_q`, set `GNT[w]`=1 and `Count`=0, and go to COUNT.
- **COUNT**:
  - If `REQ[w]`=0 (abort): `GNT`=0, `Count`=0, go to IDLE. No `DONE` is raised.
  - Else if `EVT`=1 and `Count`==`div_q`−1: `Count`=0, `DONE[w]`=1, go to REL.
  - Else if `EVT`=1: `Count`=`Count`+1.
  - Else: hold.
- **REL**:
  - `GNT[w]` and `DONE[w]` stay high.
  - When `REQ[w]`=0: clear `GNT` and `DONE`, go to IDLE.
  - `EVT` is ignored in this state.
- Divisor 1 completes on the first `EVT` sampled in COUNT.
- `EVT` is ignored in IDLE, including on the edge that enters COUNT.
- Requests from other channels are ignored while `BUSY`. They are served only after returning to IDLE.
- `Count` never exceeds `div_q`−1, and there is no wrap beyond it.
- Changing `DIV[w]` after the grant has no effect on the running job.

## Timing
- Reset values: state IDLE; `GNT`, `DONE`, `ERR`, `Count` all 0; `BUSY`=0; arbitration pointer=0.
- Reset mid-job drops the grant immediately, with no `DONE`.
- Grant latency: `REQ` seen at IDLE falling edge k → `GNT`/`BUSY` high after edge k.
- Count latency: the first `EVT` counted is at edge k+1. The Nth counted `EVT` edge raises `DONE` after that edge.
- Release: `REQ[w]` low at a REL edge → `GNT`/`DONE`/`BUSY` low after that edge. The earliest next grant is at the following edge, so there is at least one IDLE cycle between jobs.
- Abort: `REQ[w]` low at a COUNT edge → IDLE after that edge. This holds even if `EVT` is high on the same edge (abort wins).
- `ERR` pulse: high for exactly one cycle after the rejecting edge. A requester still holding `REQ` is re-evaluated on the next IDLE edge.

## Configuration
- `DIVSCHED_RR_EN` defined: round-robin arbitration.
  - The search starts at the pointer.
  - After every grant or rejection, the pointer becomes `w`+1 mod `NUM_CH`.
- `DIVSCHED_RR_EN` undefined: fixed priority, lowest index wins. The pointer logic is not built.

## Test plan
- Reset, then `REQ`=0001 with `DIV[0]`=5 and `EVT` high every cycle → `GNT`=0001 after the first edge; `Count` 0,1,2,3,4; `DONE[0]` rises on the 5th `EVT` edge; drop `REQ` → `GNT`/`DONE` clear next edge.
- `DIV[1]`=1 with `EVT` pulsed every 3rd cycle → `DONE[1]` after the first counted `EVT`; `Count` stays 0.
- `REQ`=0100 with `DIV[2]`=0 → `ERR`=0100 for one cycle, `GNT`=0, `BUSY`=0.
- Abort: `DIV[3]`=10, drop `REQ[3]` at `Count`=4 with `EVT` high → IDLE, `Count`=0, no `DONE`.
- `REQ`=1111 held and re-requested after each release:
  - with `DIVSCHED_RR_EN`, grant order is 0,1,2,3,0;
  - without it, channel 0 wins every time.
- Assert `CLEAR` mid-COUNT asynchronously → all outputs 0 immediately; after release, a pending `REQ` is granted on the next edge.
